// File: rtl/agc_lock_detector.sv
// rtl/agc_lock_detector.sv - AGC output level lock detector; optional gain freeze via AGC_LOCK_FREEZE_EN
`timescale 1ns/1ps

module agc_lock_detector #(
    parameter int SAMPLE_WH  = 16,
    parameter int WIN_LOG2   = 6,
    parameter int TARGET     = 6554,
    parameter int LOCK_TOL   = 328,
    parameter int UNLOCK_TOL = 983,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        en,
    input  logic                        restart,
    input  logic signed [SAMPLE_WH-1:0] in_real,
    input  logic signed [SAMPLE_WH-1:0] in_imag,
    output logic                        gain_en,
    output logic                        lock,
    output logic [SAMPLE_WH-1:0]        avg_mag,
    output logic                        avg_valid
);

    localparam int ACC_W = SAMPLE_WH + WIN_LOG2;
    localparam int IN_W  = $clog2(LOCK_CNT + 1);
    localparam int OUT_W = $clog2(UNLOCK_CNT + 1);

    localparam logic [SAMPLE_WH:0] TARGET_V     = (SAMPLE_WH+1)'(TARGET);
    localparam logic [SAMPLE_WH:0] LOCK_TOL_V   = (SAMPLE_WH+1)'(LOCK_TOL);
    localparam logic [SAMPLE_WH:0] UNLOCK_TOL_V = (SAMPLE_WH+1)'(UNLOCK_TOL);
    localparam logic [IN_W-1:0]    IN_LAST      = IN_W'(LOCK_CNT - 1);
    localparam logic [OUT_W-1:0]   OUT_LAST     = OUT_W'(UNLOCK_CNT - 1);

    typedef enum logic {
        ST_ACQ    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Absolute value; the most negative code has no positive twin, so clamp it
    // to the largest positive code instead of letting it wrap back negative.
    function automatic logic [SAMPLE_WH-1:0] sat_abs(input logic signed [SAMPLE_WH-1:0] x);
        logic [SAMPLE_WH-1:0] res;
        if (x == {1'b1, {(SAMPLE_WH-1){1'b0}}}) begin
            res = {1'b0, {(SAMPLE_WH-1){1'b1}}};
        end else if (x[SAMPLE_WH-1]) begin
            res = SAMPLE_WH'(-x);
        end else begin
            res = SAMPLE_WH'(x);
        end
        return res;
    endfunction

    // Magnitude estimate path
    logic [SAMPLE_WH-1:0] w_abs_i;
    logic [SAMPLE_WH-1:0] w_abs_q;
    logic [SAMPLE_WH-1:0] w_max;
    logic [SAMPLE_WH-1:0] w_min;
    logic [SAMPLE_WH-1:0] w_mag;

    logic [SAMPLE_WH-1:0] r_mag;
    logic                 r_mag_vld;

    // Window accumulation
    logic [ACC_W-1:0]     r_acc;
    logic [WIN_LOG2-1:0]  r_cnt;
    logic [ACC_W-1:0]     w_acc_sum;
    logic                 w_win_end;
    logic [SAMPLE_WH-1:0] r_avg_mag;
    logic                 r_avg_valid;

    // Deviation and lock FSM
    logic [SAMPLE_WH:0]   w_dev;
    logic                 w_in_tol;
    logic                 w_out_tol;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IN_W-1:0]      r_in_cnt;
    logic [IN_W-1:0]      w_in_cnt_nxt;
    logic [OUT_W-1:0]     r_out_cnt;
    logic [OUT_W-1:0]     w_out_cnt_nxt;
    logic                 r_lock;
    logic                 w_lock_nxt;

    // alpha-max-plus-beta-min with alpha=1, beta=1/2; peaks at 49150, fits in SAMPLE_WH bits
    always_comb begin
        w_abs_i = sat_abs(in_real);
        w_abs_q = sat_abs(in_imag);
        if (w_abs_i >= w_abs_q) begin
            w_max = w_abs_i;
            w_min = w_abs_q;
        end else begin
            w_max = w_abs_q;
            w_min = w_abs_i;
        end
        w_mag = w_max + (w_min >> 1);
    end

    // Register the magnitude of each accepted sample; restart drops any in-flight sample
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_mag     <= '0;
            r_mag_vld <= 1'b0;
        end else if (restart) begin
            r_mag     <= '0;
            r_mag_vld <= 1'b0;
        end else begin
            r_mag_vld <= en;
            if (en) begin
                r_mag <= w_mag;
            end
        end
    end

    assign w_acc_sum = r_acc + {{WIN_LOG2{1'b0}}, r_mag};
    assign w_win_end = r_mag_vld && (r_cnt == '1);

    // Accumulate accepted magnitudes; at the last sample of a window publish the
    // mean and reload the accumulator so the next sample opens a fresh window
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_avg_mag   <= '0;
            r_avg_valid <= 1'b0;
        end else if (restart) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            r_avg_valid <= w_win_end;
            if (r_mag_vld) begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= w_win_end ? '0 : w_acc_sum;
            end
            if (w_win_end) begin
                r_avg_mag <= w_acc_sum[ACC_W-1:WIN_LOG2];
            end
        end
    end

    // Distance of the published mean from the target level, plus tolerance decisions
    always_comb begin
        if ({1'b0, r_avg_mag} >= TARGET_V) begin
            w_dev = {1'b0, r_avg_mag} - TARGET_V;
        end else begin
            w_dev = TARGET_V - {1'b0, r_avg_mag};
        end
        w_in_tol  = (w_dev <= LOCK_TOL_V);
        w_out_tol = (w_dev >= UNLOCK_TOL_V);
    end

    // Lock FSM state and window-run counters
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= ST_ACQ;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_lock    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_in_cnt  <= w_in_cnt_nxt;
            r_out_cnt <= w_out_cnt_nxt;
            r_lock    <= w_lock_nxt;
        end
    end

    // Next state: only a freshly published mean moves the FSM; the band between
    // the two tolerances breaks any run in progress without voting either way
    always_comb begin
        w_state_nxt   = r_state;
        w_in_cnt_nxt  = r_in_cnt;
        w_out_cnt_nxt = r_out_cnt;
        w_lock_nxt    = r_lock;
        if (restart) begin
            w_state_nxt   = ST_ACQ;
            w_in_cnt_nxt  = '0;
            w_out_cnt_nxt = '0;
            w_lock_nxt    = 1'b0;
        end else if (r_avg_valid) begin
            case (r_state)
                ST_ACQ: begin
                    if (w_in_tol) begin
                        if (r_in_cnt == IN_LAST) begin
                            w_state_nxt   = ST_LOCKED;
                            w_lock_nxt    = 1'b1;
                            w_in_cnt_nxt  = '0;
                            w_out_cnt_nxt = '0;
                        end else begin
                            w_in_cnt_nxt = r_in_cnt + 1'b1;
                        end
                    end else begin
                        w_in_cnt_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_out_tol) begin
                        if (r_out_cnt == OUT_LAST) begin
                            w_state_nxt   = ST_ACQ;
                            w_lock_nxt    = 1'b0;
                            w_in_cnt_nxt  = '0;
                            w_out_cnt_nxt = '0;
                        end else begin
                            w_out_cnt_nxt = r_out_cnt + 1'b1;
                        end
                    end else begin
                        w_out_cnt_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt   = ST_ACQ;
                    w_in_cnt_nxt  = '0;
                    w_out_cnt_nxt = '0;
                    w_lock_nxt    = 1'b0;
                end
            endcase
        end
    end

`ifdef AGC_LOCK_FREEZE_EN
    // Hold the AGC gain steady while locked
    assign gain_en = en && (r_state == ST_ACQ);
`else
    // Lock is status only; the AGC keeps adapting on every sample
    logic w_state_unused;
    assign w_state_unused = (r_state == ST_LOCKED);
    assign gain_en = en;
`endif

    assign lock      = r_lock;
    assign avg_mag   = r_avg_mag;
    assign avg_valid = r_avg_valid;

endmodule

// File: tb/tb_agc_lock_detector.sv
// tb/tb_agc_lock_detector.sv - self-checking bench for agc_lock_detector
`timescale 1ns/1ps

module tb_agc_lock_detector;

    logic               clk = 1'b0;
    logic               nrst;
    logic               en;
    logic               restart;
    logic signed [15:0] in_real;
    logic signed [15:0] in_imag;
    logic               gain_en;
    logic               lock;
    logic [15:0]        avg_mag;
    logic               avg_valid;

    always #5 clk = ~clk;

    agc_lock_detector dut (
        .clk       (clk),
        .nrst      (nrst),
        .en        (en),
        .restart   (restart),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .gain_en   (gain_en),
        .lock      (lock),
        .avg_mag   (avg_mag),
        .avg_valid (avg_valid)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    int          sum_acc  = 0;
    int          n_acc    = 0;
    int          cyc      = 0;
    int          prev_valid_cyc = 0;
    int          last_period    = 0;
    int          valid_count    = 0;
    logic        prev_avg_valid = 1'b0;
`ifdef AGC_LOCK_FREEZE_EN
    localparam logic FREEZE = 1'b1;
`else
    localparam logic FREEZE = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_mag(input int i, input int q);
        int ai;
        int aq;
        ai = (i < 0) ? -i : i;
        aq = (q < 0) ? -q : q;
        if (ai > 32767) ai = 32767;
        if (aq > 32767) aq = 32767;
        return (ai > aq) ? ai + aq / 2 : aq + ai / 2;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: each published mean must match the oldest expected window result
    always @(negedge clk) begin
        if (nrst) begin
            if (avg_valid) begin
                if (prev_avg_valid) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL avg_valid_pulse: high for 2 cycles, expected 1");
                end
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_avg_valid: got pulse with avg_mag=%0d, expected none", avg_mag);
                end else begin
                    chk("scoreboard_avg_mag", 32'(avg_mag), 32'(exp_q.pop_front()));
                end
                last_period    = cyc - prev_valid_cyc;
                prev_valid_cyc = cyc;
                valid_count++;
            end
            prev_avg_valid = avg_valid;
        end else begin
            prev_avg_valid = 1'b0;
        end
    end

    task automatic step(input logic e, input int i, input int q, input logic rs);
        en      = e;
        restart = rs;
        in_real = 16'(i);
        in_imag = 16'(q);
        @(posedge clk);
        #1;
        if (rs) begin
            sum_acc = 0;
            n_acc   = 0;
        end else if (e) begin
            sum_acc += model_mag(i, q);
            n_acc++;
            if (n_acc == 64) begin
                exp_q.push_back(16'(sum_acc / 64));
                sum_acc = 0;
                n_acc   = 0;
            end
        end
    endtask

    task automatic feed(input int i, input int q, input int n, input logic toggle);
        for (int k = 0; k < n; k++) begin
            step(1'b1, i, q, 1'b0);
            if (toggle) step(1'b0, i, q, 1'b0);
        end
    endtask

    task automatic wait_valid();
        logic seen;
        seen    = 1'b0;
        en      = 1'b0;
        restart = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (avg_valid) seen = 1'b1;
        end
        chk("avg_valid_timeout", 32'(seen), 32'd1);
        #1;
    endtask

    task automatic window_and_wait(input int i, input int q, input logic toggle);
        feed(i, q, 64, toggle);
        wait_valid();
    endtask

    typedef struct {
        int i;
        int q;
        int exp_avg;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int vc;
        vecs[0] = '{6554, 0, 6554};
        vecs[1] = '{4000, 4000, 6000};
        vecs[2] = '{-32768, -32768, 49150};
        vecs[3] = '{0, 0, 0};
        vecs[4] = '{-6554, 0, 6554};
        vecs[5] = '{100, -300, 350};
        vecs[6] = '{32767, -32768, 49150};

        nrst    = 1'b0;
        en      = 1'b0;
        restart = 1'b0;
        in_real = '0;
        in_imag = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_lock", 32'(lock), 32'd0);
        chk("reset_avg_mag", 32'(avg_mag), 32'd0);
        chk("reset_avg_valid", 32'(avg_valid), 32'd0);
        chk("reset_gain_en", 32'(gain_en), 32'd0);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven windows of constant input
        foreach (vecs[n]) begin
            window_and_wait(vecs[n].i, vecs[n].q, 1'b0);
            chk("vec_avg_mag", 32'(avg_mag), 32'(vecs[n].exp_avg));
        end

        // Target level: lock one cycle after the 4th window, 64-cycle cadence
        step(1'b0, 0, 0, 1'b1);
        chk("restart_lock", 32'(lock), 32'd0);
        feed(6554, 0, 192, 1'b0);
        window_and_wait(6554, 0, 1'b0);
        chk("period_64", 32'(last_period), 32'd64);
        chk("lock_at_4th_valid", 32'(lock), 32'd0);
        @(negedge clk);
        chk("lock_after_4th_valid", 32'(lock), 32'd1);

        // Hysteresis band from LOCKED keeps lock
        step(1'b1, 4000, 4000, 1'b0);
        chk("gain_en_locked", 32'(gain_en), FREEZE ? 32'd0 : 32'd1);
        feed(4000, 4000, 63, 1'b0);
        wait_valid();
        @(negedge clk);
        chk("lock_hyst_1", 32'(lock), 32'd1);
        window_and_wait(4000, 4000, 1'b0);
        @(negedge clk);
        chk("lock_hyst_2", 32'(lock), 32'd1);

        // Saturated input: unlock one cycle after the 2nd out-of-tolerance window
        window_and_wait(-32768, -32768, 1'b0);
        @(negedge clk);
        chk("lock_sat_1", 32'(lock), 32'd1);
        window_and_wait(-32768, -32768, 1'b0);
        chk("lock_at_2nd_sat_valid", 32'(lock), 32'd1);
        @(negedge clk);
        chk("lock_after_2nd_sat_valid", 32'(lock), 32'd0);
        step(1'b1, 0, 0, 1'b0);
        chk("gain_en_after_unlock", 32'(gain_en), 32'd1);

        // en toggling: 128-cycle cadence, lock after 4 windows
        step(1'b0, 0, 0, 1'b1);
        feed(6554, 0, 192, 1'b1);
        window_and_wait(6554, 0, 1'b1);
        chk("period_128", 32'(last_period), 32'd128);
        chk("avg_mag_toggle", 32'(avg_mag), 32'd6554);
        chk("lock_toggle_at_valid", 32'(lock), 32'd0);
        @(negedge clk);
        chk("lock_toggle_after_valid", 32'(lock), 32'd1);

        // Restart mid-window while LOCKED
        feed(-32768, -32768, 30, 1'b0);
        step(1'b1, -32768, -32768, 1'b1);
        chk("restart_unlock", 32'(lock), 32'd0);
        chk("restart_avg_hold", 32'(avg_mag), 32'd6554);
        feed(-32768, -32768, 63, 1'b0);
        en = 1'b0;
        vc = valid_count;
        repeat (5) @(negedge clk);
        #1;
        chk("restart_no_early_valid", 32'(valid_count), 32'(vc));
        chk("restart_avg_hold_63", 32'(avg_mag), 32'd6554);
        feed(-32768, -32768, 1, 1'b0);
        wait_valid();
        chk("restart_full_window", 32'(avg_mag), 32'd49150);

        // Asynchronous reset mid-window
        feed(6554, 0, 40, 1'b0);
        #2;
        nrst = 1'b0;
        #1;
        chk("async_rst_avg_mag", 32'(avg_mag), 32'd0);
        chk("async_rst_avg_valid", 32'(avg_valid), 32'd0);
        chk("async_rst_lock", 32'(lock), 32'd0);
        sum_acc = 0;
        n_acc   = 0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        vc   = valid_count;
        feed(6554, 0, 30, 1'b0);
        en = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("async_rst_no_valid", 32'(valid_count), 32'(vc));
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
